// File: rtl/atm_pkg.sv
// Shared types for the ATM session sequencer: FSM states and screen codes.
package atm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PIN_WAIT = 3'd1,
        ST_VAL_WAIT = 3'd2,
        ST_DONE     = 3'd3,
        ST_LOCKED   = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        SCR_IDLE   = 3'd0,
        SCR_PIN    = 3'd1,
        SCR_BADPIN = 3'd2,
        SCR_VAL    = 3'd3,
        SCR_INSUF  = 3'd4,
        SCR_DONE   = 3'd5,
        SCR_LOCK   = 3'd6,
        SCR_TMO    = 3'd7
    } ecra_t;

endpackage

// File: rtl/atm_timer.sv
// Idle-cycle timer: counts enabled cycles since the last clear, flags the last allowed one.
module atm_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt;

    // Counter restarts on clear, advances on every enabled cycle.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Expiry asserted during the TIMEOUT-th enabled cycle so the state leaves on that edge.
    always_comb begin
        expire = en && (cnt == CNT_W'(TIMEOUT - 1));
    end

endmodule

// File: rtl/atm_session_ctrl.sv
// Withdrawal session sequencer: card, PIN attempts, debit, dispense pulse, lockout, timeout.
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int PIN_W     = 4,
    parameter int SALDO_W   = 4,
    parameter int MAX_TRIES = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CARD,
    input  logic [PIN_W-1:0]   PIN,
    input  logic               PIN_VALID,
    input  logic [PIN_W-1:0]   COD,
    input  logic [SALDO_W-1:0] VAL,
    input  logic               VAL_VALID,
    input  logic               CANCEL,
    input  logic               SALDO_LD,
    input  logic [SALDO_W-1:0] SALDO_IN,
    input  logic               UNLOCK,
    output logic [SALDO_W-1:0] SALDO,
    output logic [2:0]         ECRA,
    output logic               DISPENSE,
    output logic [SALDO_W-1:0] DISP_VAL,
    output logic [2:0]         TRIES,
    output logic               LOCK
);

    localparam logic [2:0] TRIES_FULL = 3'(MAX_TRIES);

    state_t             state_q, state_d;
    ecra_t              ecra_q, ecra_d;
    logic [SALDO_W-1:0] saldo_q, saldo_d;
    logic [SALDO_W-1:0] disp_val_q, disp_val_d;
    logic               dispense_q, dispense_d;
    logic [2:0]         tries_q, tries_d;
    logic               lock_q, lock_d;
    logic               card_q;
    logic               card_rise;
    logic               in_wait;
    logic               tmr_clr;
    logic               tmr_exp;

    // A session starts on card insertion (rising edge), so a card left in after a
    // cancel or timeout does not restart the session and SCR_TMO stays visible.
    assign card_rise = CARD && !card_q;
    assign in_wait   = (state_q == ST_PIN_WAIT) || (state_q == ST_VAL_WAIT);
    assign tmr_clr   = !in_wait || PIN_VALID || VAL_VALID;

    atm_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (CLK),
        .rst    (RST),
        .clr    (tmr_clr),
        .en     (in_wait),
        .expire (tmr_exp)
    );

    // State and output registers; everything visible outside is registered here.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            ecra_q     <= SCR_IDLE;
            saldo_q    <= '0;
            disp_val_q <= '0;
            dispense_q <= 1'b0;
            tries_q    <= TRIES_FULL;
            lock_q     <= 1'b0;
            card_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ecra_q     <= ecra_d;
            saldo_q    <= saldo_d;
            disp_val_q <= disp_val_d;
            dispense_q <= dispense_d;
            tries_q    <= tries_d;
            lock_q     <= lock_d;
            card_q     <= CARD;
        end
    end

    // Next-state and next-output logic; priority CARD=0 > CANCEL > timeout > strobes.
    always_comb begin
        state_d    = state_q;
        ecra_d     = ecra_q;
        saldo_d    = saldo_q;
        disp_val_d = disp_val_q;
        dispense_d = 1'b0;
        tries_d    = tries_q;
        lock_d     = lock_q;
        unique case (state_q)
            ST_IDLE: begin
                if (SALDO_LD) saldo_d = SALDO_IN;
                if (card_rise) begin
                    state_d = ST_PIN_WAIT;
                    ecra_d  = SCR_PIN;
                end
            end
            ST_PIN_WAIT: begin
                if (!CARD || CANCEL) begin
                    state_d = ST_IDLE;
                    ecra_d  = SCR_IDLE;
                end else if (tmr_exp) begin
                    state_d = ST_IDLE;
                    ecra_d  = SCR_TMO;
                end else if (PIN_VALID) begin
                    if (PIN == COD) begin
                        state_d = ST_VAL_WAIT;
                        ecra_d  = SCR_VAL;
                        tries_d = TRIES_FULL;
                    end else if (tries_q <= 3'd1) begin
                        state_d = ST_LOCKED;
                        ecra_d  = SCR_LOCK;
                        tries_d = '0;
                        lock_d  = 1'b1;
                    end else begin
                        ecra_d  = SCR_BADPIN;
                        tries_d = tries_q - 3'd1;
                    end
                end
            end
            ST_VAL_WAIT: begin
                if (!CARD || CANCEL) begin
                    state_d = ST_IDLE;
                    ecra_d  = SCR_IDLE;
                end else if (tmr_exp) begin
                    state_d = ST_IDLE;
                    ecra_d  = SCR_TMO;
                end else if (VAL_VALID && (VAL != '0)) begin
                    if (VAL <= saldo_q) begin
                        state_d    = ST_DONE;
                        ecra_d     = SCR_DONE;
                        saldo_d    = saldo_q - VAL;
                        dispense_d = 1'b1;
                        disp_val_d = VAL;
                    end else begin
                        ecra_d = SCR_INSUF;
                    end
                end
            end
            ST_DONE: begin
                if (!CARD) begin
                    state_d = ST_IDLE;
                    ecra_d  = SCR_IDLE;
                end
            end
            ST_LOCKED: begin
                if (UNLOCK) begin
                    state_d = ST_IDLE;
                    ecra_d  = SCR_IDLE;
                    tries_d = TRIES_FULL;
                    lock_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ecra_d  = SCR_IDLE;
            end
        endcase
    end

    assign SALDO    = saldo_q;
    assign ECRA     = ecra_q;
    assign DISPENSE = dispense_q;
    assign DISP_VAL = disp_val_q;
    assign TRIES    = tries_q;
    assign LOCK     = lock_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed vector bench for atm_session_ctrl (stored code 7, TIMEOUT shortened to 8).
module tb_atm_session_ctrl;

    localparam int TMO = 8;

    logic       CLK = 1'b0;
    logic       RST, CARD, PIN_VALID, VAL_VALID, CANCEL, SALDO_LD, UNLOCK;
    logic [3:0] PIN, COD, VAL, SALDO_IN;
    logic [3:0] SALDO, DISP_VAL;
    logic [2:0] ECRA, TRIES;
    logic       DISPENSE, LOCK;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        int rst, card, pin, pv, val, vv, cancel, ld, sin, unlock;
        int es, ee, ed, edv, et, el;
    } vec_t;

    vec_t vecs[$];

    atm_session_ctrl #(.PIN_W(4), .SALDO_W(4), .MAX_TRIES(3), .TIMEOUT(TMO)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CARD      (CARD),
        .PIN       (PIN),
        .PIN_VALID (PIN_VALID),
        .COD       (COD),
        .VAL       (VAL),
        .VAL_VALID (VAL_VALID),
        .CANCEL    (CANCEL),
        .SALDO_LD  (SALDO_LD),
        .SALDO_IN  (SALDO_IN),
        .UNLOCK    (UNLOCK),
        .SALDO     (SALDO),
        .ECRA      (ECRA),
        .DISPENSE  (DISPENSE),
        .DISP_VAL  (DISP_VAL),
        .TRIES     (TRIES),
        .LOCK      (LOCK)
    );

    // Free-running clock, 10 ns period.
    always #5 CLK = ~CLK;

    task automatic add(input int rst, card, pin, pv, val, vv, cancel, ld, sin, unlock,
                       input int es, ee, ed, edv, et, el);
        vec_t v;
        v = '{rst, card, pin, pv, val, vv, cancel, ld, sin, unlock, es, ee, ed, edv, et, el};
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input int es, ee, ed, edv, et, el);
        vectors++;
        if (SALDO !== 4'(es) || ECRA !== 3'(ee) || DISPENSE !== 1'(ed) ||
            DISP_VAL !== 4'(edv) || TRIES !== 3'(et) || LOCK !== 1'(el)) begin
            errors++;
            $display("FAIL %s: got saldo=%0d ecra=%0d disp=%0b dval=%0d tries=%0d lock=%0b; want saldo=%0d ecra=%0d disp=%0d dval=%0d tries=%0d lock=%0d",
                     name, SALDO, ECRA, DISPENSE, DISP_VAL, TRIES, LOCK, es, ee, ed, edv, et, el);
        end
    endtask

    task automatic quiet();
        PIN_VALID = 1'b0; VAL_VALID = 1'b0; CANCEL = 1'b0;
        SALDO_LD  = 1'b0; UNLOCK    = 1'b0; RST    = 1'b0;
    endtask

    initial begin
        COD = 4'd7;
        //  rst card pin pv val vv can ld sin unl | saldo ecra disp dval tries lock
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3, 0); // 0 reset state
        add(0, 0, 0, 0, 0, 0, 0, 1, 9, 0,   9, 0, 0, 0, 3, 0); // 1 load 9
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   9, 1, 0, 0, 3, 0); // 2 card in
        add(0, 1, 7, 1, 0, 0, 0, 0, 0, 0,   9, 3, 0, 0, 3, 0); // 3 good PIN
        add(0, 1, 0, 0, 4, 1, 0, 0, 0, 0,   5, 5, 1, 4, 3, 0); // 4 withdraw 4
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   5, 5, 0, 4, 3, 0); // 5 pulse ends
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   5, 0, 0, 4, 3, 0); // 6 card out
        add(0, 0, 0, 0, 0, 0, 0, 1, 3, 0,   3, 0, 0, 4, 3, 0); // 7 load 3
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   3, 1, 0, 4, 3, 0); // 8
        add(0, 1, 7, 1, 0, 0, 0, 0, 0, 0,   3, 3, 0, 4, 3, 0); // 9
        add(0, 1, 0, 0, 5, 1, 0, 0, 0, 0,   3, 4, 0, 4, 3, 0); // 10 insufficient
        add(0, 1, 0, 0, 0, 0, 0, 1, 9, 0,   3, 4, 0, 4, 3, 0); // 11 load ignored
        add(0, 1, 0, 0, 0, 1, 0, 0, 0, 0,   3, 4, 0, 4, 3, 0); // 12 VAL=0 ignored
        add(0, 1, 0, 0, 3, 1, 0, 0, 0, 0,   0, 5, 1, 3, 3, 0); // 13 exact balance
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 3, 3, 0); // 14
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 3, 3, 0); // 15
        add(0, 1, 2, 1, 0, 0, 0, 0, 0, 0,   0, 2, 0, 3, 2, 0); // 16 bad PIN
        add(0, 1, 3, 1, 0, 0, 0, 0, 0, 0,   0, 2, 0, 3, 1, 0); // 17 bad PIN
        add(0, 1, 0, 1, 0, 0, 0, 0, 0, 0,   0, 6, 0, 3, 0, 1); // 18 lockout
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 6, 0, 3, 0, 1); // 19 card out ignored
        add(0, 1, 7, 1, 0, 0, 0, 0, 0, 0,   0, 6, 0, 3, 0, 1); // 20 PIN ignored
        add(0, 1, 0, 0, 0, 0, 1, 0, 0, 0,   0, 6, 0, 3, 0, 1); // 21 cancel ignored
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 3, 3, 0); // 22 unlock
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 3, 3, 0); // 23
        add(0, 1, 1, 1, 0, 0, 0, 0, 0, 0,   0, 2, 0, 3, 2, 0); // 24 bad PIN
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 3, 2, 0); // 25 tries kept
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 3, 2, 0); // 26
        add(0, 1, 7, 1, 0, 0, 0, 0, 0, 0,   0, 3, 0, 3, 3, 0); // 27 tries restored
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 3, 3, 0); // 28
        add(0, 0, 0, 0, 0, 0, 0, 1, 6, 0,   6, 0, 0, 3, 3, 0); // 29 load 6
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   6, 1, 0, 3, 3, 0); // 30
        add(0, 1, 7, 1, 0, 0, 0, 0, 0, 0,   6, 3, 0, 3, 3, 0); // 31
        add(0, 1, 0, 0, 2, 1, 1, 0, 0, 0,   6, 0, 0, 3, 3, 0); // 32 cancel beats VAL
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   6, 0, 0, 3, 3, 0); // 33
        add(0, 0, 7, 1, 1, 1, 0, 0, 0, 0,   6, 0, 0, 3, 3, 0); // 34 strobes in IDLE
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   6, 1, 0, 3, 3, 0); // 35
        add(0, 1, 7, 1, 0, 0, 0, 0, 0, 0,   6, 3, 0, 3, 3, 0); // 36
        add(0, 1, 0, 0, 2, 1, 0, 0, 0, 0,   4, 5, 1, 2, 3, 0); // 37 withdraw 2
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3, 0); // 38 reset in DONE
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3, 0); // 39

        for (int i = 0; i < vecs.size(); i++) begin
            RST       = 1'(vecs[i].rst);
            CARD      = 1'(vecs[i].card);
            PIN       = 4'(vecs[i].pin);
            PIN_VALID = 1'(vecs[i].pv);
            VAL       = 4'(vecs[i].val);
            VAL_VALID = 1'(vecs[i].vv);
            CANCEL    = 1'(vecs[i].cancel);
            SALDO_LD  = 1'(vecs[i].ld);
            SALDO_IN  = 4'(vecs[i].sin);
            UNLOCK    = 1'(vecs[i].unlock);
            step();
            check($sformatf("vec%0d", i), vecs[i].es, vecs[i].ee, vecs[i].ed,
                  vecs[i].edv, vecs[i].et, vecs[i].el);
        end
        quiet();

        // Timeout in VAL_WAIT: exactly TMO idle cycles, then SCR_TMO until next insertion.
        CARD = 1'b1;
        step();
        check("tmo_card_in", 0, 1, 0, 0, 3, 0);
        PIN = 4'd7; PIN_VALID = 1'b1;
        step();
        PIN_VALID = 1'b0;
        check("tmo_pin_ok", 0, 3, 0, 0, 3, 0);
        for (int i = 1; i <= TMO; i++) begin
            step();
            check($sformatf("tmo_val_c%0d", i), 0, (i < TMO) ? 3 : 7, 0, 0, 3, 0);
        end
        step();
        check("tmo_hold_card", 0, 7, 0, 0, 3, 0);
        CARD = 1'b0;
        step();
        check("tmo_hold_nocard", 0, 7, 0, 0, 3, 0);
        CARD = 1'b1;
        step();
        check("tmo_reinsert", 0, 1, 0, 0, 3, 0);

        // A PIN strobe restarts the timeout window; tries stay decremented after abort.
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("pin_wait_c%0d", i), 0, 1, 0, 0, 3, 0);
        end
        PIN = 4'd4; PIN_VALID = 1'b1;
        step();
        PIN_VALID = 1'b0;
        check("pin_bad_restart", 0, 2, 0, 0, 2, 0);
        for (int i = 1; i <= TMO; i++) begin
            step();
            check($sformatf("pin_tmo_c%0d", i), 0, (i < TMO) ? 2 : 7, 0, 0, 2, 0);
        end
        CARD = 1'b0;
        step();
        check("pin_tmo_cardout", 0, 7, 0, 0, 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
